// File: rtl/sdram_rd_arbiter_if.sv
// Requester-side and SDRAM-side read bus shared by the two-port read arbiter.
// The arbiter connects through the master modport; the surrounding system
// (requesters plus SDRAM controller) connects through the slave modport.
interface sdram_rd_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
);
  // requester side
  logic [1:0]        rq_read_req;
  logic [ADDR_W-1:0] rq_addr0;
  logic [ADDR_W-1:0] rq_addr1;
  logic [LEN_W-1:0]  rq_len0;
  logic [LEN_W-1:0]  rq_len1;
  logic [1:0]        rq_read_req_ack;
  logic [1:0]        rq_read_en;
  logic [31:0]       rq_read_data;

  // SDRAM controller side
  logic              mem_read_req;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [LEN_W-1:0]  mem_read_len;
  logic              mem_read_req_ack;
  logic              mem_read_en;
  logic [31:0]       mem_read_data;

  modport master (
    input  rq_read_req, rq_addr0, rq_addr1, rq_len0, rq_len1,
    output rq_read_req_ack, rq_read_en, rq_read_data,
    output mem_read_req, mem_read_addr, mem_read_len,
    input  mem_read_req_ack, mem_read_en, mem_read_data
  );

  modport slave (
    output rq_read_req, rq_addr0, rq_addr1, rq_len0, rq_len1,
    input  rq_read_req_ack, rq_read_en, rq_read_data,
    input  mem_read_req, mem_read_addr, mem_read_len,
    output mem_read_req_ack, mem_read_en, mem_read_data
  );
endinterface

// File: rtl/sdram_rd_arbiter.sv
// Two-port round-robin arbiter for the SDRAM frame-buffer read port.
// One burst (base address + word count) owns the port from grant until its
// last word is delivered; a watchdog aborts bursts that stop making progress.
module sdram_rd_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  sdram_rd_arbiter_if.master bus,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic              owner;      // port holding the current burst
  logic              last;       // port that was served most recently
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [WD_W-1:0]   wd;
  logic [1:0]        ack_q;

  logic              req_any;
  logic              pick;
  logic [LEN_W-1:0]  pick_len;
  logic              beat;
  logic              progress;
  logic              wd_expire;
  logic              burst_done;

  // Arbitration choice and per-cycle progress/abort conditions.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    pick = 1'b0;
    case (bus.rq_read_req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;       // tie goes to the port not served last
      default: pick = 1'b0;
    endcase
    req_any    = |bus.rq_read_req;
    pick_len   = pick ? bus.rq_len1 : bus.rq_len0;
    beat       = (state == S_DATA) && bus.mem_read_en;
    progress   = ((state == S_REQ) && bus.mem_read_req_ack) || beat;
    wd_expire  = (state != S_IDLE) && !progress && (wd == WD_W'(TIMEOUT - 1));
    burst_done = beat && (beat_cnt == len_q - LEN_W'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_any) state_nx = S_REQ;
      S_REQ: begin
        if (bus.mem_read_req_ack) state_nx = S_DATA;
        else if (wd_expire)       state_nx = S_IDLE;
      end
      S_DATA: begin
        if (burst_done)     state_nx = S_IDLE;
        else if (wd_expire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Burst bookkeeping: latched request, beat counter, watchdog, pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      last        <= 1'b1;   // port 0 wins the first tie
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      wd          <= '0;
      ack_q       <= 2'b00;
      err_timeout <= 1'b0;
    end else begin
      ack_q       <= 2'b00;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            owner    <= pick;
            addr_q   <= pick ? bus.rq_addr1 : bus.rq_addr0;
            len_q    <= (pick_len == '0) ? LEN_W'(1) : pick_len;
            beat_cnt <= '0;
            wd       <= '0;
          end
        end
        S_REQ: begin
          if (bus.mem_read_req_ack) begin
            ack_q <= {owner, ~owner};
            last  <= owner;
            wd    <= '0;
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            last        <= owner;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            wd       <= '0;
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            last        <= owner;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; data strobes pass through with no added latency.
  always_comb begin
    busy                = (state != S_IDLE);
    grant               = busy ? {owner, ~owner} : 2'b00;
    bus.mem_read_req    = (state == S_REQ);
    bus.mem_read_addr   = addr_q;
    bus.mem_read_len    = len_q;
    bus.rq_read_req_ack = ack_q;
    bus.rq_read_en      = beat ? {owner, ~owner} : 2'b00;
    bus.rq_read_data    = bus.mem_read_data;
  end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed-vector bench for sdram_rd_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_sdram_rd_arbiter;

  localparam int ADDR_W  = 24;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       busy;
  logic       err_timeout;

  sdram_rd_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  sdram_rd_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // pulse counters, sampled at each rising edge
  int ack0_c = 0, ack1_c = 0, en0_c = 0, en1_c = 0, err_c = 0;
  always @(posedge clk) begin
    ack0_c += int'(bus.rq_read_req_ack[0]);
    ack1_c += int'(bus.rq_read_req_ack[1]);
    en0_c  += int'(bus.rq_read_en[0]);
    en1_c  += int'(bus.rq_read_en[1]);
    err_c  += int'(err_timeout);
  end

  logic [1:0] sticky = 2'b00;   // requesters that keep requesting after their ack

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to the next cycle: SDRAM strobes default low, acked requesters drop.
  task automatic advance();
    logic [1:0] a;
    a = bus.rq_read_req_ack;
    @(posedge clk);
    #1;
    bus.mem_read_req_ack = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.rq_read_req      = bus.rq_read_req & ~(a & ~sticky);
  endtask

  task automatic tick();
    advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    advance();
    rst = 1'b1;
    bus.rq_read_req = 2'b00;
    @(negedge clk);
    tick();
    advance();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mreq"}, 32'(bus.mem_read_req), 0);
    check({tag, "_maddr"}, 32'(bus.mem_read_addr), 0);
    check({tag, "_mlen"}, 32'(bus.mem_read_len), 0);
    check({tag, "_ack"}, 32'(bus.rq_read_req_ack), 0);
    check({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  // SDRAM model for one burst: wait for the request, ack after ack_dly idle
  // REQ cycles, deliver nbeats consecutive words, then confirm the block idles.
  task automatic do_burst(input int ack_dly, input int nbeats, output logic [1:0] g);
    int t;
    t = 0;
    while (bus.mem_read_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("req_seen", 32'(bus.mem_read_req), 1);
    g = grant;
    repeat (ack_dly) tick();
    advance();
    bus.mem_read_req_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nbeats; i++) begin
      advance();
      bus.mem_read_en   = 1'b1;
      bus.mem_read_data = 32'(i);
      @(negedge clk);
    end
    tick();
    check("idle_after_burst", 32'(busy), 0);
  endtask

  int          a0, a1, e0, e1, er;
  logic [1:0]  g1, g2, g3, g4;
  int          stall;
  bit          seen;

  initial begin
    bus.rq_read_req      = 2'b00;
    bus.rq_addr0         = '0;
    bus.rq_addr1         = '0;
    bus.rq_len0          = '0;
    bus.rq_len1          = '0;
    bus.mem_read_req_ack = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.mem_read_data    = '0;

    // ---- reset state
    do_reset();
    check_reset_values("rst");

    // ---- single request, port 0, addr 0x100, len 4, ack 3 cycles later
    a0 = ack0_c; a1 = ack1_c; e0 = en0_c; e1 = en1_c;
    advance();
    bus.rq_read_req = 2'b01;
    bus.rq_addr0    = 24'h000100;
    bus.rq_len0     = 16'd4;
    @(negedge clk);
    check("t1_req_cycle_mreq", 32'(bus.mem_read_req), 0);
    tick();
    check("t1_mreq", 32'(bus.mem_read_req), 1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_addr", 32'(bus.mem_read_addr), 32'h000100);
    check("t1_len", 32'(bus.mem_read_len), 4);
    repeat (2) tick();
    advance();
    bus.mem_read_req_ack = 1'b1;
    @(negedge clk);
    check("t1_no_early_ack", 32'(bus.rq_read_req_ack), 0);
    advance();
    bus.mem_read_en   = 1'b1;
    bus.mem_read_data = 32'hCAFE0001;
    @(negedge clk);
    check("t1_ack_pulse", 32'(bus.rq_read_req_ack), 32'h1);
    check("t1_mreq_dropped", 32'(bus.mem_read_req), 0);
    check("t1_en_first_beat", 32'(bus.rq_read_en), 32'h1);
    check("t1_data", bus.rq_read_data, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) begin
      advance();
      bus.mem_read_en = 1'b1;
      @(negedge clk);
    end
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_grant", 32'(grant), 0);
    check("t1_ack0_count", 32'(ack0_c - a0), 1);
    check("t1_ack1_count", 32'(ack1_c - a1), 0);
    check("t1_en0_count", 32'(en0_c - e0), 4);
    check("t1_en1_count", 32'(en1_c - e1), 0);

    // ---- simultaneous requests from reset, len 2, three rounds: 0,1,0
    do_reset();
    sticky = 2'b11;
    advance();
    bus.rq_read_req = 2'b11;
    bus.rq_len0     = 16'd2;
    bus.rq_len1     = 16'd2;
    @(negedge clk);
    do_burst(1, 2, g1);
    do_burst(1, 2, g2);
    do_burst(1, 2, g3);
    check("t2_round1", 32'(g1), 32'h1);
    check("t2_round2", 32'(g2), 32'h2);
    check("t2_round3", 32'(g3), 32'h1);

    // ---- port 1 continuous, port 0 once: 1, 1, 0, 1
    do_reset();
    sticky = 2'b10;
    advance();
    bus.rq_read_req = 2'b10;
    @(negedge clk);
    do_burst(0, 2, g1);
    advance();
    bus.rq_read_req[0] = 1'b1;
    @(negedge clk);
    do_burst(0, 2, g2);
    do_burst(0, 2, g3);
    do_burst(0, 2, g4);
    check("t3_p1_first", 32'(g1), 32'h2);
    check("t3_p1_second", 32'(g2), 32'h2);
    check("t3_p0_not_starved", 32'(g3), 32'h1);
    check("t3_p1_again", 32'(g4), 32'h2);

    // ---- stall: ack, one beat of three, then silence
    do_reset();
    sticky = 2'b00;
    er = err_c;
    advance();
    bus.rq_read_req = 2'b01;
    bus.rq_len0     = 16'd3;
    @(negedge clk);
    tick();
    advance();
    bus.mem_read_req_ack = 1'b1;
    @(negedge clk);
    advance();
    bus.mem_read_en = 1'b1;
    @(negedge clk);
    stall = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (err_timeout) seen = 1'b1;
      else if (busy)   stall++;
    end
    check("t4_timeout_seen", 32'(seen), 1);
    check("t4_stall_cycles", 32'(stall), TIMEOUT);
    check("t4_grant_cleared", 32'(grant), 0);
    tick();
    check("t4_err_one_cycle", 32'(err_timeout), 0);
    check("t4_err_count", 32'(err_c - er), 1);
    a0 = ack0_c;
    advance();
    bus.rq_read_req = 2'b01;
    @(negedge clk);
    do_burst(1, 3, g1);
    check("t4_recover_grant", 32'(g1), 32'h1);
    check("t4_recover_ack", 32'(ack0_c - a0), 1);

    // ---- length 0 is treated as one word
    do_reset();
    e0 = en0_c;
    advance();
    bus.rq_read_req = 2'b01;
    bus.rq_addr0    = 24'h000055;
    bus.rq_len0     = 16'd0;
    @(negedge clk);
    tick();
    check("t5_len_one", 32'(bus.mem_read_len), 1);
    do_burst(0, 1, g1);
    check("t5_beats", 32'(en0_c - e0), 1);

    // ---- stray beat while idle, then reset during DATA
    do_reset();
    advance();
    bus.mem_read_en = 1'b1;
    @(negedge clk);
    check("t6_stray_en", 32'(bus.rq_read_en), 0);
    tick();
    check("t6_stray_idle", 32'(busy), 0);
    advance();
    bus.rq_read_req = 2'b10;
    bus.rq_addr1    = 24'hABCDEF;
    bus.rq_len1     = 16'd4;
    @(negedge clk);
    tick();
    check("t6_addr1", 32'(bus.mem_read_addr), 32'hABCDEF);
    advance();
    bus.mem_read_req_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      advance();
      bus.mem_read_en = 1'b1;
      @(negedge clk);
    end
    advance();
    rst             = 1'b1;
    bus.mem_read_en = 1'b1;
    @(negedge clk);
    advance();
    bus.mem_read_en = 1'b1;
    @(negedge clk);
    check_reset_values("t6_midrst");
    check("t6_midrst_en", 32'(bus.rq_read_en), 0);
    advance();
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
